// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
//   Receives 8N1 UART frames, LSB first, from an asynchronous serial line. Each
//   complete byte goes into a small first-word-fall-through FIFO, which is read
//   out on a ready/valid stream. Framing and overrun errors appear as one-cycle
//   pulses.
//
//   Optional feature: define UART_RX_PARITY_EN to receive 8E1 frames (11 bits).
//   A PARITY state is added, even parity is checked over the data bits, and
//   o_parity_err is added. A byte that fails the parity check is dropped.
//
// Ports
//   i_clk        system clock, rising edge
//   i_rst        asynchronous, active-high reset
//   i_uart_rx    serial line, idle high, asynchronous to i_clk
//   o_data       byte at the FIFO head (reads 0 while the FIFO is empty)
//   o_valid      FIFO not empty
//   i_ready      consumer takes o_data when o_valid && i_ready
//   o_frame_err  one-cycle pulse: stop bit sampled low
//   o_overrun    one-cycle pulse: byte completed while the FIFO was full
//   o_parity_err one-cycle pulse: parity mismatch (UART_RX_PARITY_EN only)
//   o_level      current FIFO occupancy, 0..FIFO_DEPTH
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int BAUD_RATE   = 115200,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_uart_rx,
    output logic [7:0]                    o_data,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic                          o_frame_err,
    output logic                          o_overrun,
`ifdef UART_RX_PARITY_EN
    output logic                          o_parity_err,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   o_level
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int TW           = $clog2(CLKS_PER_BIT);
    localparam int AW           = $clog2(FIFO_DEPTH);

    localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2);
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   LVL_FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    // ------------------------------------------------------------------------
    // Input synchronizer. Both flops reset to the idle level so that reset
    // release cannot look like a start edge.
    // ------------------------------------------------------------------------
    logic rx_meta, rx_s;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_uart_rx;
            rx_s    <= rx_meta;
        end
    end

    // ------------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------------
    state_t          state, state_nx;
    logic [TW-1:0]   timer;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;
    logic            tick;       // sample point for the current state
    logic            stop_tick;  // stop-bit sample, either polarity
    logic            stop_ok;    // stop bit sampled high
    logic            fe_set;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        tick      = 1'b0;
        stop_tick = 1'b0;
        stop_ok   = 1'b0;
        fe_set    = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) state_nx = START;
            end
            START: begin
                // Mid-start-bit check. A line that has already gone high
                // was a glitch and is ignored.
                if (timer == T_HALF) begin
                    tick     = 1'b1;
                    state_nx = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (timer == T_LAST) begin
                    tick = 1'b1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_nx = PARITY;
`else
                        state_nx = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (timer == T_LAST) begin
                    tick     = 1'b1;
                    state_nx = STOP;
                end
            end
`endif
            STOP: begin
                if (timer == T_LAST) begin
                    tick      = 1'b1;
                    stop_tick = 1'b1;
                    if (rx_s) begin
                        stop_ok  = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        fe_set   = 1'b1;
                        state_nx = BREAK;
                    end
                end
            end
            BREAK: begin
                // Hold here while the line stays low so that a break is not
                // seen as a stream of zero frames.
                if (rx_s) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // The timer restarts at every sample point. After the half-bit start
    // sample, each later sample therefore lands near the middle of its bit.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)                                  timer <= '0;
        else if (state == IDLE || state == BREAK)   timer <= '0;
        else if (tick)                              timer <= '0;
        else                                        timer <= timer + 1'b1;
    end

`ifdef UART_RX_PARITY_EN
    logic par_bad;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bit_idx <= '0;
            shift   <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
        end else if (tick) begin
            if (state == START) bit_idx <= '0;
            if (state == DATA) begin
                shift   <= {rx_s, shift[7:1]};   // LSB arrives first
                bit_idx <= bit_idx + 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            // Even parity: data bits and parity bit must XOR to zero.
            if (state == PARITY) par_bad <= ^{rx_s, shift};
`endif
        end
    end

    // ------------------------------------------------------------------------
    // FIFO (first-word-fall-through)
    // ------------------------------------------------------------------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push, pop, full, wr_en, ovr_set;

`ifdef UART_RX_PARITY_EN
    assign push = stop_ok && !par_bad;
`else
    assign push = stop_ok;
`endif
    assign full    = (count == LVL_FULL);
    assign pop     = o_valid && i_ready;
    // When the FIFO is full, a pop in the same cycle frees the slot being written.
    assign wr_en   = push && (!full || pop);
    assign ovr_set = push && full && !pop;

    always_ff @(posedge i_clk) begin
        if (wr_en) mem[wr_ptr] <= shift;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;   // wraps at FIFO_DEPTH
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign o_valid = (count != '0);
    assign o_level = count;
    // mem has no reset, so the empty case is forced to 0.
    assign o_data  = o_valid ? mem[rd_ptr] : 8'h00;

    // ------------------------------------------------------------------------
    // Error pulses, registered and one cycle long
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_frame_err  <= 1'b0;
            o_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            o_parity_err <= 1'b0;
`endif
        end else begin
            o_frame_err  <= fe_set;
            o_overrun    <= ovr_set;
`ifdef UART_RX_PARITY_EN
            o_parity_err <= stop_tick && par_bad;
`endif
        end
    end

`ifndef UART_RX_PARITY_EN
    // stop_tick is only consumed by the parity check.
    logic unused_stop_tick;
    assign unused_stop_tick = stop_tick;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
//   Directed bench for uart_rx_fifo at 16 clocks per bit with FIFO_DEPTH = 4.
//   The stimulus pushes each expected byte into a queue. A monitor pops the
//   queue on every o_valid && i_ready cycle and compares. The same monitor
//   counts error pulses and checks that o_data stays stable while it is stalled.
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo;
    localparam int CPB = 16;

    logic       tb_clk = 1'b0;
    logic       rst, rx, ready;
    logic [7:0] o_data;
    logic       o_valid, o_frame_err, o_overrun;
    logic [2:0] o_level;
`ifdef UART_RX_PARITY_EN
    logic       o_parity_err;
`endif

    always #5 tb_clk = ~tb_clk;

    uart_rx_fifo #(
        .CLK_FREQ_HZ (1600),
        .BAUD_RATE   (100),
        .FIFO_DEPTH  (4)
    ) dut (
        .i_clk       (tb_clk),
        .i_rst       (rst),
        .i_uart_rx   (rx),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (ready),
        .o_frame_err (o_frame_err),
        .o_overrun   (o_overrun),
`ifdef UART_RX_PARITY_EN
        .o_parity_err(o_parity_err),
`endif
        .o_level     (o_level)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    int         fe_cnt = 0, ov_cnt = 0, pop_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: runs just after each falling edge. At that point the inputs for
    // the next rising edge are already driven.
    initial begin : monitor
        logic       hold;
        logic [7:0] hold_data;
        logic [7:0] e;
        hold      = 1'b0;
        hold_data = 8'h00;
        forever begin
            @(negedge tb_clk);
            #1;
            if (rst) begin
                hold = 1'b0;
            end else begin
                if (o_frame_err) fe_cnt++;
                if (o_overrun)   ov_cnt++;
                if (hold && o_valid) check("data_hold", o_data, hold_data);
                if (o_valid && ready) begin
                    pop_cnt++;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_pop: got 0x%0h expected no byte", o_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("pop_data", o_data, e);
                    end
                end
                hold      = o_valid && !ready;
                hold_data = o_data;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

    task automatic clks(input int n);
        repeat (n) @(negedge tb_clk);
    endtask

    // Drives one frame, one clock per step, starting at a falling edge. The
    // stop bit is held low for stop_low bit times before the line returns
    // high. If pulse_at >= 0, ready is high only during step pulse_at.
    task automatic send_frame(input logic [7:0] b, input int stop_low, input int pulse_at);
        int total;
        total = CPB * (10 + stop_low);
        for (int c = 0; c < total; c++) begin
            int bi;
            bi = c / CPB;
            if (bi == 0)                 rx = 1'b0;
            else if (bi <= 8)            rx = b[bi-1];
            else if (bi < 9 + stop_low)  rx = 1'b0;
            else                         rx = 1'b1;
            if (pulse_at >= 0) ready = (c == pulse_at);
            @(negedge tb_clk);
        end
        rx = 1'b1;
    endtask

    task automatic drain(input string name);
        ready = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge tb_clk);
        clks(2);
        check(name, exp_q.size(), 0);
    endtask

    int fe0, ov0, pc0;

    initial begin
        rst = 1'b1; rx = 1'b1; ready = 1'b0;
        clks(3);
        check("rst_valid", o_valid, 0);
        check("rst_level", o_level, 0);
        check("rst_data", o_data, 0);
        check("rst_frame_err", o_frame_err, 0);
        check("rst_overrun", o_overrun, 0);
        rst = 1'b0;
        clks(5);

        // Single byte
        ready = 1'b1;
        fe0 = fe_cnt; ov0 = ov_cnt; pc0 = pop_cnt;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 0, -1);
        clks(4);
        check("single_drained", exp_q.size(), 0);
        check("single_pops", pop_cnt - pc0, 1);
        check("single_level", o_level, 0);
        check("single_no_fe", fe_cnt - fe0, 0);
        check("single_no_ov", ov_cnt - ov0, 0);

        // Back-to-back into a stalled FIFO, fifth byte overruns
        ready = 1'b0;
        ov0 = ov_cnt;
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_q.push_back(8'(i));
            send_frame(8'(i), 0, -1);
        end
        check("full_level", o_level, 4);
        check("full_overrun", ov_cnt - ov0, 1);
        check("full_head", o_data, 8'h01);
        drain("full_drained");
        check("full_level_after", o_level, 0);

        // Framing error with the stop bit held low, then a clean byte
        ready = 1'b1;
        fe0 = fe_cnt; pc0 = pop_cnt;
        send_frame(8'h3C, 3, -1);
        clks(32);
        check("fe_pulse_once", fe_cnt - fe0, 1);
        check("fe_level", o_level, 0);
        check("fe_no_pop", pop_cnt - pc0, 0);
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 0, -1);
        clks(4);
        check("fe_next_byte", exp_q.size(), 0);
        check("fe_no_more", fe_cnt - fe0, 1);

        // Glitch shorter than half a bit
        fe0 = fe_cnt; ov0 = ov_cnt; pc0 = pop_cnt;
        rx = 1'b0;
        clks(4);
        rx = 1'b1;
        clks(40);
        check("glitch_no_pop", pop_cnt - pc0, 0);
        check("glitch_no_fe", fe_cnt - fe0, 0);
        check("glitch_no_ov", ov_cnt - ov0, 0);
        check("glitch_level", o_level, 0);

        // Reset mid-frame, with a byte left in the FIFO beforehand
        ready = 1'b0;
        send_frame(8'h5A, 0, -1);
        clks(2);
        check("prerst_level", o_level, 1);
        rx = 1'b0;  clks(CPB);          // start bit of 0xFF
        rx = 1'b1;  clks(3*CPB + CPB/2); // bits 0..2 and half of bit 3
        rst = 1'b1;
        clks(2);
        check("midrst_valid", o_valid, 0);
        check("midrst_level", o_level, 0);
        check("midrst_data", o_data, 0);
        check("midrst_fe", o_frame_err, 0);
        check("midrst_ov", o_overrun, 0);
        rst = 1'b0;
        clks(200);
        check("postrst_level", o_level, 0);
        ready = 1'b1;
        pc0 = pop_cnt;
        exp_q.push_back(8'h42);
        send_frame(8'h42, 0, -1);
        clks(4);
        check("postrst_drained", exp_q.size(), 0);
        check("postrst_pops", pop_cnt - pc0, 1);

        // Push and pop in the same cycle while full. The stop-bit sample lands
        // on the rising edge after step 155 of the frame.
        ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(8'(i * 8'h11));
            send_frame(8'(i * 8'h11), 0, -1);
        end
        check("simul_full_level", o_level, 4);
        ov0 = ov_cnt;
        exp_q.push_back(8'h99);
        send_frame(8'h99, 0, 155);
        check("simul_no_ov", ov_cnt - ov0, 0);
        check("simul_level", o_level, 4);
        drain("simul_drained");
        check("simul_level_after", o_level, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
